// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type and helpers for the sequential binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int MAX_DIGITS = 32;
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction
  function automatic int lead_digits(input logic [4*MAX_DIGITS-1:0] v, input int digits);
    int n;
    n = 1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < digits && v[4*i+:4] != 4'd0) n = i + 1;
    return n;
  endfunction
endpackage

// File: rtl/bcd_seq_converter_if.sv
// bcd_seq_converter_if: start/done handshake and result bus of the converter
interface bcd_seq_converter_if #(parameter int BIN_W = 14, parameter int DIGITS = 4);
  logic                           start;
  logic [BIN_W-1:0]               bin;
  logic                           busy;
  logic                           done;
  logic [4*DIGITS-1:0]            bcd;
  logic                           overflow;
  logic [$clog2(DIGITS+1)-1:0]    nz_digits;
  modport master (output start, bin, input busy, done, bcd, overflow, nz_digits);
  modport slave (input start, bin, output busy, done, bcd, overflow, nz_digits);
endinterface

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: double-dabble correction of one BCD digit, wraps in 4 bits
module bcd_add3_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: one-bit-per-clock shift-and-add-3 binary-to-BCD converter
module bcd_seq_converter import bcd_pkg::*; #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input logic               clk,
  input logic               rst,
  bcd_seq_converter_if.slave io
);
  localparam int CW = cnt_w(BIN_W);
  localparam int BW = 4 * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);
  state_t          state;
  logic [BIN_W-1:0] shreg, sh_nx;
  logic [BW-1:0]   work, corr, work_nx;
  logic [CW-1:0]   cnt;
  logic [NW-1:0]   nz_nx;
  logic            ovf_acc, top_bit, ovf_nx, last;
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (.d(work[4*g+:4]), .q(corr[4*g+:4]));
  end
  // the bit falling off the top digit means the value no longer fits
  always_comb begin
    {top_bit, work_nx, sh_nx} = {corr, shreg, 1'b0};
    ovf_nx = ovf_acc | top_bit;
    last = cnt == CW'(BIN_W - 1);
    nz_nx = NW'(lead_digits((4*MAX_DIGITS)'(work_nx), DIGITS));
  end
  assign io.busy = state == SHIFT;
  assign io.done = state == DONE;
  always_ff @(posedge clk)
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      work         <= '0;
      cnt          <= '0;
      ovf_acc      <= 1'b0;
      io.bcd       <= '0;
      io.overflow  <= 1'b0;
      io.nz_digits <= NW'(1);
    end else if (state == SHIFT) begin
      work    <= work_nx;
      shreg   <= sh_nx;
      ovf_acc <= ovf_nx;
      cnt     <= cnt + CW'(1);
      if (last) begin
        state        <= DONE;
        io.bcd       <= work_nx;
        io.overflow  <= ovf_nx;
        io.nz_digits <= nz_nx;
      end
    end else if (io.start) begin
      state   <= SHIFT;
      shreg   <= io.bin;
      work    <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else begin
      state <= IDLE;
    end
endmodule

// File: doc/bcd_seq_converter.md
# bcd_seq_converter

Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble). It processes one input bit per clock, so area stays flat as width grows. It sits between binary arithmetic results and the seven-segment and display-formatting logic. It adds a start/done handshake, an overflow flag for inputs that do not fit in DIGITS decimal digits, and a significant-digit count for leading-zero blanking.

## Interface

Parameters:
- BIN_W, 14: binary input width, ≥ 1.
- DIGITS, 4: number of BCD output digits, ≥ 1.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a conversion; accepted when busy is low.
- bin  in  BIN_W  unsigned binary operand; sampled only on the accepting edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd, overflow and nz_digits are valid from this cycle.
- bcd  out  4*DIGITS  result; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- overflow  out  1  high when bin > 10^DIGITS − 1.
- nz_digits  out  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS; value 1 for zero.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on start.
  - On entry: bin is loaded into the shift register.
  - The BCD working register, the overflow accumulator and the bit counter clear to 0.
- SHIFT, each cycle:
  - Every working digit ≥ 5 gets +3 (4-bit wrap, never carries).
  - The concatenation {work, shreg} then shifts left by 1.
  - The MSB shifted out of the top digit is ORed into the overflow accumulator.
  - The counter increments; after BIN_W shifts the FSM goes to DONE.
- DONE, one cycle:
  - done = 1.
  - bcd, overflow and nz_digits load from the working state and are held until the next DONE.
  - → SHIFT if start is high, otherwise → IDLE.
- On overflow, bcd holds bin mod 10^DIGITS (the lower digits), not a saturated value.
- nz_digits = index of the highest non-zero digit + 1, or 1 if all digits are zero. It is computed from the final digits, independent of overflow.
- start while busy = 1 is ignored, with no queuing.
- When 10^DIGITS > 2^BIN_W − 1, overflow is constant 0 by construction. No parameter check is required.

## Timing

- Reset values: busy=0, done=0, bcd=0, overflow=0, nz_digits=1; FSM in IDLE.
- busy = (state == SHIFT).
- If start is accepted at edge N:
  - busy is high for edges N..N+BIN_W−1.
  - done is high for the cycle following edge N+BIN_W.
  - Latency from accept to done is BIN_W+1 cycles.
- Back-to-back operation: start held high during DONE is accepted at once. Throughput is one conversion per BIN_W+1 cycles.
- Reset mid-conversion aborts at the next edge and all outputs return to their reset values. No done pulse is produced for the aborted operation.
- bin may change freely after the accepting edge.

## Structure

- Package bcd_pkg holds:
  - the state typedef (IDLE/SHIFT/DONE);
  - a localparam function computing the counter width, $clog2(BIN_W+1);
  - a leading-digit function returning nz_digits from a digit vector.
- Sub-module bcd_add3_digit: 4-bit combinational correction (in ≥ 5 → in+3, else in). It is instantiated DIGITS times with a generate loop.
- The top level holds the FSM, counter, shift registers and output registers.

## Test plan

- BIN_W=14, DIGITS=4, bin=9999, start pulse → done after 15 cycles; bcd=16'h9999, overflow=0, nz_digits=4.
- bin=0 → bcd=16'h0000, overflow=0, nz_digits=1. bin=42 → bcd=16'h0042, nz_digits=2.
- bin=16383 → bcd=16'h6383, overflow=1, nz_digits=4. bin=10000 → bcd=16'h0000, overflow=1, nz_digits=1.
- start held high for 3 conversions, with bin=1, 2, 3 presented when each start is accepted → done pulses 15 cycles apart; results 0001, 0002, 0003. Extra start pulses while busy have no effect.
- Assert rst 5 cycles into a conversion of 1234 → next cycle busy=0, bcd=0, nz_digits=1, and no done pulse. A fresh start then yields 16'h1234.
- BIN_W=20, DIGITS=7, exhaustive random sample (≥ 10k values) against a reference model → every result is exact, overflow=0, and latency is exactly 21 cycles.
